// File: rtl/mux_readout.sv
// N-way MCU read mux: IDLE->WAIT->HOLD handshake with registered data/ack/err/busy; ack 2 cycles after rd_req when data valid.
// Optional WAIT timeout enabled by defining MUX_READOUT_TIMEOUT_EN (otherwise TIMEOUT is only range-checked).
module mux_readout #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [$clog2(N)-1:0] cs_addr,
  input  logic                 rd_req,
  input  logic [N*WIDTH-1:0]   module_outputs,
  input  logic [N-1:0]         module_valid,
  output logic [WIDTH-1:0]     output_to_mc,
  output logic                 rd_ack,
  output logic                 rd_err,
  output logic                 busy
);

  localparam int AW = $clog2(N);

  if (N < 2) begin : g_chk_n
    $error("mux_readout: N must be >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
    $error("mux_readout: TIMEOUT must be within 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    w_addr_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_busy;
  // Set once rd_req has been seen low; a new transaction only starts while armed.
  logic             r_armed;
  logic             w_start;
  logic             w_addr_bad;
  logic [WIDTH-1:0] w_slice;
  logic             w_slice_vld;

`ifdef MUX_READOUT_TIMEOUT_EN
  logic [15:0]      r_cnt;
  logic             w_timeout;
  assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));
`endif

  assign w_addr_bad  = (32'(cs_addr) >= 32'(N));
  assign w_slice     = module_outputs[32'(r_addr) * WIDTH +: WIDTH];
  assign w_slice_vld = module_valid[r_addr];
  assign w_start     = (r_state == S_IDLE) && rd_req && r_armed;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_ack_nxt   = r_ack;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        w_err_nxt = 1'b0;
        if (w_start) begin
          w_addr_nxt = cs_addr;
          if (w_addr_bad) begin
            w_state_nxt = S_HOLD;
            w_err_nxt   = 1'b1;
            w_data_nxt  = '0;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!rd_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_slice_vld) begin
          w_state_nxt = S_HOLD;
          w_ack_nxt   = 1'b1;
          w_data_nxt  = w_slice;
        end
`ifdef MUX_READOUT_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_nxt = S_HOLD;
          w_err_nxt   = 1'b1;
          w_data_nxt  = '0;
        end
`endif
      end
      S_HOLD: begin
        if (!rd_req) begin
          w_state_nxt = S_IDLE;
          w_ack_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt == S_WAIT);
      if (!rd_req) begin
        r_armed <= 1'b1;
      end else if (w_start) begin
        r_armed <= 1'b0;
      end
    end
  end

`ifdef MUX_READOUT_TIMEOUT_EN
  // Counter idles at zero outside WAIT, so every WAIT entry starts from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`endif

  assign output_to_mc = r_data;
  assign rd_ack       = r_ack;
  assign rd_err       = r_err;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mux_readout.sv
// Randomized + directed bench for mux_readout against a transaction-level reference model.
// Timeout expectations follow MUX_READOUT_TIMEOUT_EN when it is defined for the build.
module tb_mux_readout;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     cs_addr;
  logic           rd_req;
  logic [N*W-1:0] mo;
  logic [N-1:0]   mv;
  logic [W-1:0]   output_to_mc;
  logic           rd_ack, rd_err, busy;

  logic [1:0]     d3_addr;
  logic           d3_req;
  logic [3*W-1:0] d3_mo;
  logic [2:0]     d3_mv;
  logic [W-1:0]   d3_out;
  logic           d3_ack, d3_err, d3_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_readout #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cs_addr(cs_addr), .rd_req(rd_req),
    .module_outputs(mo), .module_valid(mv), .output_to_mc(output_to_mc),
    .rd_ack(rd_ack), .rd_err(rd_err), .busy(busy)
  );

  mux_readout #(.N(3), .WIDTH(W), .TIMEOUT(TO)) dut3 (
    .clk(clk), .reset(reset), .cs_addr(d3_addr), .rd_req(d3_req),
    .module_outputs(d3_mo), .module_valid(d3_mv), .output_to_mc(d3_out),
    .rd_ack(d3_ack), .rd_err(d3_err), .busy(d3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a pending read, a completed (held) result, and a "needs rd_req low" flag.
  bit          m_ack, m_err, m_wait, m_need_low;
  logic [W-1:0] m_data;
  int          m_addr, m_waited;

  function automatic void model_reset();
    m_ack = 0; m_err = 0; m_wait = 0; m_need_low = 1;
    m_data = '0; m_addr = 0; m_waited = 0;
  endfunction

  function automatic void model_step();
    bit started = 0;
    if (m_ack || m_err) begin
      if (!rd_req) begin m_ack = 0; m_err = 0; end
    end else if (m_wait) begin
      if (!rd_req) m_wait = 0;
      else if (mv[m_addr]) begin
        m_data = mo[m_addr*W +: W]; m_ack = 1; m_wait = 0;
      end
`ifdef MUX_READOUT_TIMEOUT_EN
      else if (m_waited == TO - 1) begin
        m_err = 1; m_data = '0; m_wait = 0;
      end
`endif
      else m_waited++;
    end else if (rd_req && !m_need_low) begin
      started = 1;
      if (int'(cs_addr) >= N) begin
        m_err = 1; m_data = '0;
      end else begin
        m_wait = 1; m_waited = 0; m_addr = int'(cs_addr);
      end
    end
    if (!rd_req) m_need_low = 0;
    else if (started) m_need_low = 1;
  endfunction

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk({tag, ".ack"},  32'(rd_ack), 32'(m_ack));
    chk({tag, ".err"},  32'(rd_err), 32'(m_err));
    chk({tag, ".busy"}, 32'(busy), 32'(m_wait));
    chk({tag, ".data"}, 32'(output_to_mc), 32'(m_data));
    chk({tag, ".excl"}, 32'(rd_ack & rd_err), 32'd0);
  endtask

  initial begin
    reset = 1'b0; rd_req = 1'b0; cs_addr = '0; mo = '0; mv = '0;
    d3_addr = '0; d3_req = 1'b0; d3_mo = '0; d3_mv = '0;
    model_reset();
    #1;
    chk("rst.data", 32'(output_to_mc), 32'd0);
    chk("rst.ack",  32'(rd_ack), 32'd0);
    chk("rst.err",  32'(rd_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.d3",   32'({d3_out, d3_ack, d3_err, d3_busy}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle("idle");

    // N=3: address 3 is out of range, address 2 is served normally
    d3_addr = 2'd3; d3_req = 1'b1;
    cycle("d3bad");
    chk("d3bad.err",  32'(d3_err), 32'd1);
    chk("d3bad.ack",  32'(d3_ack), 32'd0);
    chk("d3bad.data", 32'(d3_out), 32'd0);
    d3_req = 1'b0;
    cycle("d3rel");
    chk("d3rel.err", 32'(d3_err), 32'd0);
    d3_mo[2*W +: W] = 16'hBEEF; d3_mv = 3'b100; d3_addr = 2'd2; d3_req = 1'b1;
    cycle("d3a"); cycle("d3b");
    chk("d3ok.ack",  32'(d3_ack), 32'd1);
    chk("d3ok.data", 32'(d3_out), 32'hBEEF);
    d3_req = 1'b0;
    cycle("d3end");
    chk("d3end.ack", 32'(d3_ack), 32'd0);

    // Valid already high: ack two cycles after the request
    mv = 4'hF; mo = {$urandom, $urandom}; mo[2*W +: W] = 16'hA5A5; cs_addr = 2'd2; rd_req = 1'b1;
    cycle("lat1");
    chk("lat1.busy", 32'(busy), 32'd1);
    chk("lat1.ack",  32'(rd_ack), 32'd0);
    cycle("lat2");
    chk("lat2.ack",  32'(rd_ack), 32'd1);
    chk("lat2.data", 32'(output_to_mc), 32'hA5A5);
    mo = {$urandom, $urandom}; cs_addr = 2'd0;
    repeat (3) cycle("hold");
    chk("hold.data", 32'(output_to_mc), 32'hA5A5);

    // Async reset during HOLD with rd_req still high
    #2 reset = 1'b0;
    #1;
    chk("rsth.zero", 32'({output_to_mc, rd_ack, rd_err, busy}), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cycle("rsth.idle");
    chk("rsth.noack", 32'(rd_ack), 32'd0);
    rd_req = 1'b0;
    cycle("rsth.low");
    mo[2*W +: W] = 16'hA5A5; cs_addr = 2'd2; rd_req = 1'b1;
    cycle("rsth.a"); cycle("rsth.b");
    chk("rsth.ack",  32'(rd_ack), 32'd1);
    chk("rsth.data", 32'(output_to_mc), 32'hA5A5);
    rd_req = 1'b0;
    cycle("rsth.rel");
    chk("rsth.keep", 32'(output_to_mc), 32'hA5A5);

    // Late valid; address changes during WAIT are ignored
    mv = 4'b1101; mo[1*W +: W] = 16'h1234; mo[3*W +: W] = 16'hDEAD; cs_addr = 2'd1; rd_req = 1'b1;
    cycle("late.enter");
    cs_addr = 2'd3;
    repeat (6) cycle("late.wait");
    chk("late.busy", 32'(busy), 32'd1);
    mv[1] = 1'b1;
    cycle("late.done");
    chk("late.ack",  32'(rd_ack), 32'd1);
    chk("late.data", 32'(output_to_mc), 32'h1234);
    rd_req = 1'b0;
    cycle("late.rel");

    // Abort in WAIT keeps the previous data
    mv = '0; cs_addr = 2'd0; rd_req = 1'b1;
    repeat (3) cycle("abort.wait");
    rd_req = 1'b0;
    cycle("abort");
    chk("abort.flags", 32'({rd_ack, rd_err, busy}), 32'd0);
    chk("abort.data",  32'(output_to_mc), 32'h1234);

    // Never-valid source
    cs_addr = 2'd1; rd_req = 1'b1;
    repeat (12) cycle("tmo");
`ifdef MUX_READOUT_TIMEOUT_EN
    chk("tmo.err",  32'(rd_err), 32'd1);
    chk("tmo.data", 32'(output_to_mc), 32'd0);
    chk("tmo.busy", 32'(busy), 32'd0);
`else
    repeat (30) cycle("tmo.long");
    chk("tmo.busy", 32'(busy), 32'd1);
    chk("tmo.err",  32'(rd_err), 32'd0);
`endif
    rd_req = 1'b0;
    cycle("tmo.rel");

    // Randomized traffic
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
      cs_addr = 2'($urandom);
      mv = 4'($urandom & $urandom);
      mo = {$urandom, $urandom};
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
